// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues single-outstanding instruction fetches and
// holds the fetched word in a one-entry buffer for decode, squashing wrong-path data.
module fetch_sequencer #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  output logic [31:0]     inst_out,
  output logic [XLEN-1:0] inst_pc,
  input  logic            dec_ready,
  output logic            redir_misalign
);

  typedef enum logic [1:0] {StIdle, StIssue, StSquash} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            inst_valid_q, inst_valid_d;
  logic [31:0]     inst_out_q;
  logic [XLEN-1:0] inst_pc_q;
  logic            misalign_q;
  logic            load;
  logic [XLEN-1:0] redir_pc;

  assign redir_pc = {redir_target[XLEN-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // addr_q captures the request address at issue so a squashed request keeps it
  // while pc_q already tracks the redirect target.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (redir_valid) begin
          pc_d = redir_pc;
        end else if (!stall && (!inst_valid_q || dec_ready)) begin
          state_d = StIssue;
          addr_d  = pc_q;
        end
      end
      StIssue: begin
        if (imem_ack) begin
          state_d = StIdle;
          if (redir_valid) begin
            pc_d = redir_pc;
          end else begin
            load = 1'b1;
            pc_d = pc_q + XLEN'(4);
          end
        end else if (redir_valid) begin
          state_d = StSquash;
          pc_d    = redir_pc;
        end
      end
      StSquash: begin
        if (redir_valid) begin
          pc_d = redir_pc;
        end
        if (imem_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    inst_valid_d = inst_valid_q;
    if ((inst_valid_q && dec_ready) || redir_valid) begin
      inst_valid_d = 1'b0;
    end
    if (load) begin
      inst_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_out_q   <= '0;
      inst_pc_q    <= '0;
      misalign_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      inst_valid_q <= inst_valid_d;
      misalign_q   <= redir_valid && (redir_target[1:0] != 2'b00);
      if (load) begin
        inst_out_q <= imem_rdata;
        inst_pc_q  <= pc_q;
      end
    end
  end

  always_comb begin
    imem_req       = (state_q != StIdle);
    imem_addr      = addr_q;
    inst_valid     = inst_valid_q;
    inst_out       = inst_out_q;
    inst_pc        = inst_pc_q;
    redir_misalign = misalign_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer: per-cycle vectors plus a
// hand-written reset-during-squash sequence.
module tb_fetch_sequencer;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            stall;
  logic            redir_valid;
  logic [XLEN-1:0] redir_target;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            inst_valid;
  logic [31:0]     inst_out;
  logic [XLEN-1:0] inst_pc;
  logic            dec_ready;
  logic            redir_misalign;

  fetch_sequencer #(
    .XLEN    (XLEN),
    .RESET_PC(32'd32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .redir_valid   (redir_valid),
    .redir_target  (redir_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst_out      (inst_out),
    .inst_pc       (inst_pc),
    .dec_ready     (dec_ready),
    .redir_misalign(redir_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rt;
    logic        ack;
    logic [31:0] rdata;
    logic        dr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_out;
    logic [31:0] e_pc;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];
  int   n_tests;
  int   n_fail;

  task automatic add(input logic st, input logic rv, input logic [31:0] rt, input logic ack,
                     input logic [31:0] rd, input logic dr, input logic e_req,
                     input logic [31:0] e_addr, input logic e_iv, input logic [31:0] e_out,
                     input logic [31:0] e_pc, input logic e_mis);
    vec_t v;
    v = '{st, rv, rt, ack, rd, dr, e_req, e_addr, e_iv, e_out, e_pc, e_mis};
    vecs.push_back(v);
  endtask

  // Address is checked only while a request is up; buffer contents only while valid.
  task automatic check(input string name, input logic e_req, input logic [31:0] e_addr,
                       input logic e_iv, input logic [31:0] e_out, input logic [31:0] e_pc,
                       input logic e_mis, input logic force_all);
    logic ok;
    ok = (imem_req === e_req) && (inst_valid === e_iv) && (redir_misalign === e_mis);
    if (e_req || force_all) ok = ok && (imem_addr === e_addr);
    if (e_iv || force_all) ok = ok && (inst_out === e_out) && (inst_pc === e_pc);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got req=%b addr=%h iv=%b out=%h pc=%h mis=%b, want req=%b addr=%h iv=%b out=%h pc=%h mis=%b",
               name, imem_req, imem_addr, inst_valid, inst_out, inst_pc, redir_misalign,
               e_req, e_addr, e_iv, e_out, e_pc, e_mis);
    end
  endtask

  task automatic drive(input logic st, input logic rv, input logic [31:0] rt, input logic ack,
                       input logic [31:0] rd, input logic dr);
    stall        = st;
    redir_valid  = rv;
    redir_target = rt;
    imem_ack     = ack;
    imem_rdata   = rd;
    dec_ready    = dr;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(0, 0, 0, 0, 0, 1);

    //   st rv target        ack rdata         dr | req addr          iv out           pc            mis
    // Sequential fetch at zero wait: 32, 36, 40
    add(0, 0, 0,            0, 0,            1,   0, 0,            0, 0,            0,            0);
    add(0, 0, 0,            1, 32'hA0A0_0000, 1,  1, 32,           0, 0,            0,            0);
    add(0, 0, 0,            0, 0,            1,   0, 0,            1, 32'hA0A0_0000, 32,          0);
    add(0, 0, 0,            1, 32'hA1A1_0001, 1,  1, 36,           0, 0,            0,            0);
    add(0, 0, 0,            0, 0,            1,   0, 0,            1, 32'hA1A1_0001, 36,          0);
    add(0, 0, 0,            1, 32'hA2A2_0002, 1,  1, 40,           0, 0,            0,            0);
    // Buffer full for four cycles, then decode accepts
    add(0, 0, 0,            0, 0,            0,   0, 0,            1, 32'hA2A2_0002, 40,          0);
    add(0, 0, 0,            0, 0,            0,   0, 0,            1, 32'hA2A2_0002, 40,          0);
    add(0, 0, 0,            0, 0,            0,   0, 0,            1, 32'hA2A2_0002, 40,          0);
    add(0, 0, 0,            0, 0,            1,   0, 0,            1, 32'hA2A2_0002, 40,          0);
    // Slow memory, redirect to 0x100 in 2nd wait cycle, old address held until ack
    add(0, 0, 0,            0, 0,            1,   1, 44,           0, 0,            0,            0);
    add(0, 1, 32'h100,      0, 0,            1,   1, 44,           0, 0,            0,            0);
    add(0, 0, 0,            0, 0,            1,   1, 44,           0, 0,            0,            0);
    add(0, 0, 0,            0, 0,            1,   1, 44,           0, 0,            0,            0);
    add(0, 0, 0,            0, 0,            1,   1, 44,           0, 0,            0,            0);
    add(0, 0, 0,            1, 32'hDEAD_BEEF, 1,  1, 44,           0, 0,            0,            0);
    add(0, 0, 0,            0, 0,            1,   0, 0,            0, 0,            0,            0);
    add(0, 0, 0,            1, 32'hB0B0_0100, 1,  1, 32'h100,      0, 0,            0,            0);
    // Misaligned redirect flushes a held instruction
    add(0, 1, 32'h102,      0, 0,            0,   0, 0,            1, 32'hB0B0_0100, 32'h100,     0);
    add(0, 0, 0,            0, 0,            1,   0, 0,            0, 0,            0,            1);
    add(0, 0, 0,            1, 32'hB1B1_0100, 1,  1, 32'h100,      0, 0,            0,            0);
    // Redirect wins over issue in IDLE; then wrap-around at top of address space
    add(0, 1, 32'hFFFF_FFFC, 0, 0,           1,   0, 0,            1, 32'hB1B1_0100, 32'h100,     0);
    add(0, 0, 0,            0, 0,            1,   0, 0,            0, 0,            0,            0);
    add(0, 0, 0,            1, 32'hC0C0_FFFC, 1,  1, 32'hFFFF_FFFC, 0, 0,           0,            0);
    add(0, 0, 0,            0, 0,            1,   0, 0,            1, 32'hC0C0_FFFC, 32'hFFFF_FFFC, 0);
    // Stall does not drop an outstanding request but blocks the next issue
    add(1, 0, 0,            0, 0,            1,   1, 0,            0, 0,            0,            0);
    add(1, 0, 0,            1, 32'hC1C1_0000, 1,  1, 0,            0, 0,            0,            0);
    add(1, 0, 0,            0, 0,            1,   0, 0,            1, 32'hC1C1_0000, 0,           0);
    add(0, 0, 0,            0, 0,            1,   0, 0,            0, 0,            0,            0);
    // Ack and redirect together: data dropped
    add(0, 1, 32'h200,      1, 32'hBAD0_0004, 1,  1, 4,            0, 0,            0,            0);
    add(0, 0, 0,            0, 0,            1,   0, 0,            0, 0,            0,            0);
    // Two redirects while squashing: latest wins, address held
    add(0, 1, 32'h303,      0, 0,            1,   1, 32'h200,      0, 0,            0,            0);
    add(0, 1, 32'h400,      0, 0,            1,   1, 32'h200,      0, 0,            0,            1);
    add(0, 0, 0,            1, 32'hBAD0_0200, 1,  1, 32'h200,      0, 0,            0,            0);
    add(0, 0, 0,            0, 0,            1,   0, 0,            0, 0,            0,            0);
    add(0, 0, 0,            1, 32'hD0D0_0400, 1,  1, 32'h400,      0, 0,            0,            0);
    add(0, 0, 0,            0, 0,            1,   0, 0,            1, 32'hD0D0_0400, 32'h400,     0);

    @(negedge clk);
    check("reset_state", 1'b0, 32'd32, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_iv,
            vecs[i].e_out, vecs[i].e_pc, vecs[i].e_mis, 1'b0);
      drive(vecs[i].stall, vecs[i].rv, vecs[i].rt, vecs[i].ack, vecs[i].rdata, vecs[i].dr);
    end

    // Reset asserted while squashing; a late ack during reset is ignored
    @(negedge clk);
    check("pre_squash", 1'b1, 32'h404, 1'b0, 0, 0, 1'b0, 1'b0);
    drive(0, 1, 32'h500, 0, 0, 1);
    @(negedge clk);
    check("in_squash", 1'b1, 32'h404, 1'b0, 0, 0, 1'b0, 1'b0);
    drive(0, 0, 0, 0, 0, 1);
    #1 rst_n = 1'b0;
    #1 check("async_reset", 1'b0, 32'd32, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    drive(0, 0, 0, 1, 32'hBAD0_0404, 1);
    @(negedge clk);
    @(negedge clk);
    check("ack_in_reset", 1'b0, 32'd32, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    drive(0, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
    check("post_reset_idle", 1'b0, 32'd32, 1'b0, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    check("post_reset_fetch", 1'b1, 32'd32, 1'b0, 0, 0, 1'b0, 1'b0);
    drive(0, 0, 0, 1, 32'hE0E0_0020, 1);
    @(negedge clk);
    check("post_reset_data", 1'b0, 32'd32, 1'b1, 32'hE0E0_0020, 32'd32, 1'b0, 1'b0);
    drive(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("post_reset_next", 1'b1, 32'd36, 1'b0, 0, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
